jk_debounce: RTL and testbench
==============================

Name: jk_debounce

Overview:
- Upstream input-conditioning stage for the J/K-driven asynchronous-reset Moore FSM.
- Takes two raw, bouncy, asynchronous inputs (set request, clear request) and synchronises and debounces each one.
- Emits clean single-cycle j/k pulses on each debounced rising edge; these drive the FSM's j/k inputs directly.
- Simultaneous j and k pulses are allowed; the downstream FSM interprets them as toggle.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive post-sync samples needed to accept a level change; legal range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width; derived, never overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_on_raw  input  1  raw asynchronous set request.
- btn_off_raw  input  1  raw asynchronous clear request.
- j  output  1  registered one-cycle pulse on a debounced rising edge of btn_on_raw.
- k  output  1  registered one-cycle pulse on a debounced rising edge of btn_off_raw.
- on_lvl  output  1  registered debounced level of btn_on_raw.
- off_lvl  output  1  registered debounced level of btn_off_raw.

Behaviour:
- Reset (async assert, sync release): sync flops, counters, states, j, k, on_lvl and off_lvl all go to 0. All outputs read 0 while reset is high.
- Each channel is independent and identical: a 2-flop synchroniser (s1→s2) feeds a 4-state FSM plus a counter.
- FSM states:
  - LO_STABLE: lvl=0; s2=1 → WAIT_HI with cnt=1.
  - WAIT_HI: s2=1 → cnt+1; s2=0 → LO_STABLE with cnt=0 (glitch rejected).
  - HI_STABLE: lvl=1; s2=0 → WAIT_LO with cnt=1.
  - WAIT_LO: mirror of WAIT_HI.
- Acceptance: when cnt reaches DEBOUNCE_CYCLES (checked as cnt+1==DEBOUNCE_CYCLES, or entry with DEBOUNCE_CYCLES=1), the FSM goes to the opposite STABLE state, updates lvl and clears cnt, all on the same edge.
- Pulse: on LO→HI acceptance, j (or k) is 1 for exactly one cycle; there is no pulse on HI→LO acceptance.
- Latency: raw held high from rising edge E0 → j high after edge E0+DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)-th sampling edge. on_lvl rises on the same edge as j.
- Counter never exceeds DEBOUNCE_CYCLES; no wrap is possible.
- Simultaneous acceptance on both channels → j and k both high in the same cycle. No arbitration is done here.
- Held input produces one pulse only; re-arming requires a debounced release.
- Reset mid-count discards the partial count. A raw input still high after reset release must re-qualify fully, then pulses once.

Optional Feature:
- Macro JK_DEBOUNCE_HOLD_EN.
- Defined: j/k are level outputs equal to on_lvl/off_lvl, following every debounced level change (same latency). No edge detection, so a held request holds j/k high.
- Undefined (default): one-cycle pulse behaviour as specified above.

Decomposition:
- Package jk_debounce_pkg:
  - typedef enum for channel state {LO_STABLE, WAIT_HI, HI_STABLE, WAIT_LO}, 2-bit encoding.
  - Constant SYNC_STAGES=2.
- Sub-module debounce_ch (ports clk, reset, raw, lvl, rise_pulse; parameter DEBOUNCE_CYCLES), instantiated twice. The top adds only output muxing for JK_DEBOUNCE_HOLD_EN.

Test Plan:
- Reset: reset=1 for 2 cycles with both raw=1 → j=k=on_lvl=off_lvl=0 throughout. After release, j pulses once at edge 6 (DEBOUNCE_CYCLES=4).
- Clean press: btn_on_raw 0→1 and held 20 cycles → j=1 for exactly one cycle after the 6th sampling edge, on_lvl=1 from then on. Release → on_lvl=0 six edges later, j stays 0.
- Bounce: btn_on_raw pattern 1,1,0,1,1,1,0,... (never 4 consecutive highs) → j and on_lvl stay 0. A following run of 4+ highs → a single j pulse.
- Simultaneous: both raws rise on the same edge → j=k=1 in the same cycle. Hooked to the FSM: its output toggles 0→1, and a repeat toggles 1→0.
- Mid-count reset: btn_off_raw high 4 cycles, async reset pulse between edges, raw held → k is not seen until the full 6 edges after release.
- DEBOUNCE_CYCLES=1 build: a single-cycle raw high (after sync) → k pulse at edge 3. With JK_DEBOUNCE_HOLD_EN: held input → k level stays high while held.

Source files
------------

// File: rtl/jk_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_debounce_pkg
//  Description : Shared types and constants for the jk_debounce input
//                conditioning stage (per-channel debounce state encoding,
//                synchroniser depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_debounce_pkg;

    // Number of flops in the metastability synchroniser in front of each FSM.
    localparam int SYNC_STAGES = 2;

    // Per-channel debounce state. STABLE states own the accepted level,
    // WAIT states are qualifying a candidate change of that level.
    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        WAIT_HI   = 2'd1,
        HI_STABLE = 2'd2,
        WAIT_LO   = 2'd3
    } ch_state_t;

endpackage : jk_debounce_pkg
`default_nettype wire

// File: rtl/jk_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel. A two-flop synchroniser feeds a
//                four-state qualification FSM with a saturating-by-design
//                counter. Produces the registered debounced level and a
//                one-cycle pulse on every accepted low-to-high transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
    import jk_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic lvl,
    output logic rise_pulse
);

    // Counter only ever needs to hold values up to DEBOUNCE_CYCLES-1 in the
    // WAIT states, but is sized for DEBOUNCE_CYCLES so the compare target fits.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_target = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero   = '0;

    // With a single-sample requirement the first differing sample is
    // accepted immediately, so the WAIT states are never entered.
    localparam logic c_single = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s2;

    ch_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_cnt_done;
    logic                   r_lvl;
    logic                   r_pulse;

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign w_s2       = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc  = r_cnt + c_one;
    assign w_cnt_done = (w_cnt_inc == c_target);

    // Qualification FSM: level, counter and rise pulse all update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LO_STABLE;
            r_cnt   <= c_zero;
            r_lvl   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            // The pulse is asserted only on the accepting edge below.
            r_pulse <= 1'b0;
            case (r_state)
                LO_STABLE: begin
                    if (w_s2) begin
                        if (c_single) begin
                            r_state <= HI_STABLE;
                            r_lvl   <= 1'b1;
                            r_pulse <= 1'b1;
                            r_cnt   <= c_zero;
                        end else begin
                            r_state <= WAIT_HI;
                            r_cnt   <= c_one;
                        end
                    end
                end

                WAIT_HI: begin
                    if (w_s2) begin
                        if (w_cnt_done) begin
                            r_state <= HI_STABLE;
                            r_lvl   <= 1'b1;
                            r_pulse <= 1'b1;
                            r_cnt   <= c_zero;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end else begin
                        // Glitch: the candidate high did not persist.
                        r_state <= LO_STABLE;
                        r_cnt   <= c_zero;
                    end
                end

                HI_STABLE: begin
                    if (!w_s2) begin
                        if (c_single) begin
                            r_state <= LO_STABLE;
                            r_lvl   <= 1'b0;
                            r_cnt   <= c_zero;
                        end else begin
                            r_state <= WAIT_LO;
                            r_cnt   <= c_one;
                        end
                    end
                end

                WAIT_LO: begin
                    if (!w_s2) begin
                        if (w_cnt_done) begin
                            // Falling acceptance carries no pulse.
                            r_state <= LO_STABLE;
                            r_lvl   <= 1'b0;
                            r_cnt   <= c_zero;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= HI_STABLE;
                        r_cnt   <= c_zero;
                    end
                end

                default: begin
                    r_state <= LO_STABLE;
                    r_cnt   <= c_zero;
                    r_lvl   <= 1'b0;
                end
            endcase
        end
    end

    assign lvl        = r_lvl;
    assign rise_pulse = r_pulse;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/jk_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : jk_debounce
//  Description : Input conditioning for the J/K Moore FSM. Synchronises and
//                debounces the raw set/clear requests and emits registered
//                j/k pulses on each debounced rising edge, plus the
//                debounced levels. Simultaneous j and k are passed through
//                unchanged (downstream treats them as toggle).
//  Config      : JK_DEBOUNCE_HOLD_EN - when defined, j/k follow the debounced
//                levels instead of pulsing once per rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_debounce
    import jk_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_on_raw,
    input  logic btn_off_raw,
    output logic j,
    output logic k,
    output logic on_lvl,
    output logic off_lvl
);

    logic w_on_lvl;
    logic w_on_rise;
    logic w_off_lvl;
    logic w_off_rise;

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_on (
        .clk        (clk),
        .reset      (reset),
        .raw        (btn_on_raw),
        .lvl        (w_on_lvl),
        .rise_pulse (w_on_rise)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_off (
        .clk        (clk),
        .reset      (reset),
        .raw        (btn_off_raw),
        .lvl        (w_off_lvl),
        .rise_pulse (w_off_rise)
    );

    assign on_lvl  = w_on_lvl;
    assign off_lvl = w_off_lvl;

`ifdef JK_DEBOUNCE_HOLD_EN
    // Level mode: a rise pulse always coincides with the level going high,
    // so merging it in leaves j/k equal to the debounced levels.
    assign j = w_on_lvl  | w_on_rise;
    assign k = w_off_lvl | w_off_rise;
`else
    // Pulse mode: one registered cycle per debounced rising edge.
    assign j = w_on_rise;
    assign k = w_off_rise;
`endif

endmodule : jk_debounce
`default_nettype wire

// File: tb/tb_jk_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_debounce
//  Description : Self-checking bench for jk_debounce (DEBOUNCE_CYCLES=4 main
//                instance, DEBOUNCE_CYCLES=1 side instance). Expected j/k
//                events are queued by the stimulus and consumed by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_debounce;

    localparam int D   = 4;
    localparam int LAT = D + 2;

    logic clk = 1'b0;
    logic reset;
    logic btn_on_raw, btn_off_raw;
    logic j, k, on_lvl, off_lvl;

    logic on1_raw, off1_raw;
    logic j1, k1, on1_lvl, off1_lvl;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   cyc;
        logic j;
        logic k;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic q;

    jk_debounce #(.DEBOUNCE_CYCLES(D)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .btn_on_raw  (btn_on_raw),
        .btn_off_raw (btn_off_raw),
        .j           (j),
        .k           (k),
        .on_lvl      (on_lvl),
        .off_lvl     (off_lvl)
    );

    jk_debounce #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .btn_on_raw  (on1_raw),
        .btn_off_raw (off1_raw),
        .j           (j1),
        .k           (k1),
        .on_lvl      (on1_lvl),
        .off_lvl     (off1_lvl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream J/K register model driven by the DUT pulses.
    always @(posedge clk or posedge reset) begin
        if (reset)          q <= 1'b0;
        else if (j && k)    q <= ~q;
        else if (j)         q <= 1'b1;
        else if (k)         q <= 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input logic ej, input logic ek);
        exp_t x;
        x.cyc = at;
        x.j   = ej;
        x.k   = ek;
        sb.push_back(x);
    endtask

    // Monitor: every j/k pulse of the main instance must match the queue head.
    always @(negedge clk) begin
        if (!reset && (j || k)) begin
            if (sb.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse actual j=%0b k=%0b expected none (cycle %0d)", j, k, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_jk", {30'd0, j, k}, {30'd0, e.j, e.k});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int r;
        int x;
        int p;
        int m;
        int c;
        logic [12:0] bounce;

        reset       = 1'b1;
        btn_on_raw  = 1'b1;
        btn_off_raw = 1'b1;
        on1_raw     = 1'b0;
        off1_raw    = 1'b0;

        // Reset held with both requests high: everything stays low.
        wait_cyc(1);
        check("reset_outs_a", {28'd0, j, k, on_lvl, off_lvl}, 32'd0);
        wait_cyc(1);
        check("reset_outs_b", {28'd0, j, k, on_lvl, off_lvl}, 32'd0);
        reset = 1'b0;
        r = cyc;
        // Requests still high after release: both qualify together -> toggle.
        expect_pulse(r + LAT, 1'b1, 1'b1);
        wait_cyc(LAT - 1);
        check("lvl_before_accept", {30'd0, on_lvl, off_lvl}, 32'd0);
        wait_cyc(1);
        check("lvl_at_accept", {30'd0, on_lvl, off_lvl}, 32'd3);
        wait_cyc(2);
        check("fsm_toggle_on", {31'd0, q}, 32'd1);
        wait_cyc(12);
        check("lvl_held", {30'd0, on_lvl, off_lvl}, 32'd3);

        // Release both: levels drop six edges later, no pulses.
        btn_on_raw  = 1'b0;
        btn_off_raw = 1'b0;
        x = cyc;
        wait_cyc(LAT - 1);
        check("release_lvl_still_hi", {30'd0, on_lvl, off_lvl}, 32'd3);
        wait_cyc(1);
        check("release_lvl_lo", {30'd0, on_lvl, off_lvl}, 32'd0);
        wait_cyc(4);

        // Clean press on the set request, held 20 cycles.
        btn_on_raw = 1'b1;
        p = cyc;
        expect_pulse(p + LAT, 1'b1, 1'b0);
        wait_cyc(20);
        check("press_lvl", {30'd0, on_lvl, off_lvl}, 32'd2);
        btn_on_raw = 1'b0;
        wait_cyc(10);
        check("press_release_lvl", {31'd0, on_lvl}, 32'd0);

        // Bounce: never four consecutive highs -> nothing accepted.
        bounce = 13'b1101110101110;
        for (int i = 12; i >= 0; i--) begin
            btn_on_raw = bounce[i];
            wait_cyc(1);
        end
        btn_on_raw = 1'b0;
        wait_cyc(6);
        check("bounce_lvl", {31'd0, on_lvl}, 32'd0);

        // A following clean run of highs -> single pulse.
        btn_on_raw = 1'b1;
        p = cyc;
        expect_pulse(p + LAT, 1'b1, 1'b0);
        wait_cyc(8);
        check("bounce_run_lvl", {31'd0, on_lvl}, 32'd1);
        btn_on_raw = 1'b0;
        wait_cyc(10);

        // Simultaneous rise again: downstream toggles back to 0.
        check("fsm_before_toggle", {31'd0, q}, 32'd1);
        btn_on_raw  = 1'b1;
        btn_off_raw = 1'b1;
        p = cyc;
        expect_pulse(p + LAT, 1'b1, 1'b1);
        wait_cyc(LAT + 2);
        check("fsm_toggle_off", {31'd0, q}, 32'd0);
        btn_on_raw  = 1'b0;
        btn_off_raw = 1'b0;
        wait_cyc(10);

        // Mid-count reset on the clear request: partial count discarded.
        btn_off_raw = 1'b1;
        wait_cyc(4);
        m = cyc;
        #1 reset = 1'b1;
        #1;
        check("midreset_outs", {28'd0, j, k, on_lvl, off_lvl}, 32'd0);
        reset = 1'b0;
        expect_pulse(m + LAT, 1'b0, 1'b1);
        wait_cyc(LAT - 1);
        check("midreset_lvl_pending", {31'd0, off_lvl}, 32'd0);
        wait_cyc(1);
        check("midreset_lvl", {31'd0, off_lvl}, 32'd1);
        btn_off_raw = 1'b0;
        wait_cyc(10);

        // DEBOUNCE_CYCLES=1 instance: single-cycle request -> k at edge 3.
        off1_raw = 1'b1;
        c = cyc;
        wait_cyc(1);
        off1_raw = 1'b0;
        check("d1_k_edge1", {31'd0, k1}, 32'd0);
        wait_cyc(1);
        check("d1_k_edge2", {31'd0, k1}, 32'd0);
        wait_cyc(1);
        check("d1_k_edge3", {31'd0, k1}, 32'd1);
        check("d1_lvl_edge3", {31'd0, off1_lvl}, 32'd1);
        check("d1_cycle", cyc, c + 3);
        wait_cyc(1);
        check("d1_k_edge4", {31'd0, k1}, 32'd0);
        check("d1_lvl_edge4", {31'd0, off1_lvl}, 32'd0);
        check("d1_j_quiet", {30'd0, j1, on1_lvl}, 32'd0);

        // Every queued pulse must have been observed.
        wait_cyc(10);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jk_debounce
`default_nettype wire
